// File: rtl/nibble_unswap_rx.sv
// Receive-side nibble unswap with optional byte-lane reversal, buffered in a 2-entry FIFO.
// Optional even-parity check on restored words: define NIBBLE_UNSWAP_RX_PARITY_EN.
module nibble_unswap_rx #(
    parameter int WIDTH    = 32,
    parameter int LANE_REV = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt
`ifdef NIBBLE_UNSWAP_RX_PARITY_EN
    ,
    input  logic             in_par,
    output logic             par_err
`endif
);

    localparam int NB = WIDTH / 8;

    // Handshake: a word moves on any posedge where valid & ready are both high.
    // in_ready and out_valid depend only on registered FIFO occupancy, so neither
    // side sees a combinational path from the other; a full FIFO refuses input
    // even in a cycle where it is also being drained.
    logic [WIDTH-1:0] swapped;
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    for (genvar i = 0; i < NB; i++) begin : g_byte
        localparam int S = (LANE_REV != 0) ? (NB - 1 - i) : i;
        assign swapped[8*i +: 8] = {in_data[8*S +: 4], in_data[8*S+4 +: 4]};
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            word_cnt <= '0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= swapped;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                word_cnt <= word_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef NIBBLE_UNSWAP_RX_PARITY_EN
    // Swapping nibbles and lanes preserves the XOR of all bits, so the
    // transmitter's parity is checked directly against the restored word.
    logic par_mem [2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_mem[0] <= 1'b0;
            par_mem[1] <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            if (push) begin
                par_mem[wr_ptr] <= in_par;
            end
            if (pop && ((^out_data) != par_mem[rd_ptr])) begin
                par_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/nibble_unswap_rx.md
Name: nibble_unswap_rx

Overview:
- Receive-side inverse of the byte nibble-swap and lane-move path.
- Accepts WIDTH-bit words whose bytes carry swapped nibbles, optionally in reversed lane order, and restores the original byte layout.
- Streams through a 2-entry FIFO with valid/ready on both sides.
- Counts delivered words; sits between the swapped-transmit stage and the consumer.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8 and at least 8.
- LANE_REV, 1, 1 = output byte i taken from input byte (WIDTH/8-1-i); 0 = output byte i taken from input byte i.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  nibble-swapped word.
- out_valid  output  1  restored word available.
- out_ready  input  1  downstream accepts a word.
- out_data  output  WIDTH  restored word.
- word_cnt  output  CNT_W  number of output handshakes since reset.

Behaviour:
- Transform, purely combinational on the write side, applied before storage:
  - Let s = LANE_REV ? (WIDTH/8-1-i) : i.
  - stored byte i = {in_data[8s+3:8s], in_data[8s+7:8s+4]}.
- Storage: 2-entry FIFO with wr_ptr, rd_ptr (1 bit each) and count (0..2).
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != 2). It is registered-state only, with no combinational path from out_ready. When full, in_ready = 0 even if a pop occurs in that same cycle.
- out_valid = (count != 0). out_data = entry[rd_ptr], held stable while out_valid & !out_ready.
- Latency: a word pushed at edge N is presented with out_valid = 1 after edge N (next cycle); no bypass path.
- Count update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged (count 1 → stays 1).
- Pointers advance independently on push and on pop and wrap 1 → 0.
- Ordering is strict FIFO; no word is dropped or duplicated.
- word_cnt increments by 1 on each pop and wraps from all-ones to 0.
- Reset, when rst_n = 0 at posedge:
  - count = 0, wr_ptr = 0, rd_ptr = 0, word_cnt = 0.
  - out_valid = 0, in_ready = 1.
  - out_data = 0; storage is cleared to 0.
- Reset mid-operation discards buffered words, and the in-flight handshake of that cycle is ignored.
- in_valid may be driven while in_ready = 0; no push occurs and the word must be held by upstream.
- X on in_data while in_valid = 0 must not propagate into storage. Storage is written only on push.

Optional Feature:
- Macro: NIBBLE_UNSWAP_RX_PARITY_EN.
- When defined, adds these ports:
  - in_par  input  1  even parity of the original, unswapped word as sent by the transmitter.
  - par_err  output  1  sticky parity error flag.
- in_par is stored alongside each FIFO entry.
- On each pop, if ^out_data != stored parity, par_err is set to 1 from the next cycle. It stays 1 until reset; reset value is 0.
- Nibble swap and lane reversal do not change the XOR of all bits, so parity is checked on restored data.
- When not defined: no extra ports, no parity storage, behaviour otherwise identical.

Test Plan:
- Reset then single word, LANE_REV=1, in_data=0x12345678, out_ready=1 → out_valid one cycle later; out_data=0x87654321; word_cnt=1.
- LANE_REV=0 instance, in_data=0x12345678 → out_data=0x21436587; in_data=0xA5A5A5A5 → out_data=0x5A5A5A5A.
- Backpressure:
  - Stimulus: out_ready=0; push 0x00000001, 0x00000002, then present 0x00000003.
  - Required: in_ready=0 after the second push; the third word is not accepted; out_data holds 0x10000000 (LANE_REV=1).
  - Then raise out_ready: outputs are 0x10000000, 0x20000000, then 0x30000000 after it is accepted; order is preserved.
- Simultaneous push and pop with count=1, continuous stream of 8 words with in_valid=1 and out_ready=1 → in_ready stays 1, one word out per cycle, word_cnt=8.
- Reset mid-stream:
  - Stimulus: count=2; assert rst_n=0 for one cycle while in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1, word_cnt=0; the word presented during reset is not stored.
- Parity (macro defined):
  - Send 0x12345678 with correct in_par=1 → par_err stays 0.
  - Then send 0x00000001 with in_par=0 → par_err=1 the cycle after its pop; it remains 1 through later correct words until rst_n=0.
